// File: rtl/bus_rr_sched_if.sv
// Packet-bus bundle between the driver FIFOs, the round-robin scheduler and the receivers.
// The master modport is the scheduler side; the slave modport is the FIFO/receiver side.
interface bus_rr_sched_if #(
  parameter int unsigned DRVRS   = 8,
  parameter int unsigned PCKG_SZ = 24
) ();

  logic [DRVRS-1:0]         pndng;
  logic [DRVRS*PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]         pop;
  logic [DRVRS-1:0]         push;
  logic [PCKG_SZ-1:0]       D_push;
  logic                     busy;
  logic [3:0]               grant_id;
  logic [15:0]              xfer_cnt;
  logic [7:0]               drop_cnt;

  modport master (
    input  pndng, D_pop,
    output pop, push, D_push, busy, grant_id, xfer_cnt, drop_cnt
  );

  modport slave (
    output pndng, D_pop,
    input  pop, push, D_push, busy, grant_id, xfer_cnt, drop_cnt
  );

endinterface

// File: rtl/bus_rr_sched.sv
// Round-robin scheduler: grants one driver FIFO per 3-cycle transaction, pops its head word
// and pushes it to the receiver named by the destination byte, or to all others on broadcast.
module bus_rr_sched #(
  parameter int unsigned DRVRS     = 8,
  parameter int unsigned PCKG_SZ   = 24,
  parameter logic [7:0]  BROADCAST = 8'hFF
) (
  input logic            clk,
  input logic            reset,
  bus_rr_sched_if.master bus
);

  typedef enum logic [1:0] {StIdle, StPop, StPush} state_e;

  state_e             state_q, state_d;
  logic [3:0]         ptr_q, ptr_d;
  logic [3:0]         grant_q, grant_d;
  logic [PCKG_SZ-1:0] pkt_q, pkt_d;
  logic [PCKG_SZ-1:0] d_push_q, d_push_d;
  logic [DRVRS-1:0]   pop_q, pop_d;
  logic [DRVRS-1:0]   push_q, push_d;
  logic               busy_q, busy_d;
  logic [15:0]        xfer_q, xfer_d;
  logic [7:0]         drop_q, drop_d;

  // Arbitration: first pending driver at or after ptr, wrapping modulo DRVRS.
  logic [15:0] pndng_ext;
  logic [4:0]  idx;
  logic        found;
  logic [3:0]  sel;

  always_comb begin
    pndng_ext = 16'(bus.pndng);
    idx       = '0;
    found     = 1'b0;
    sel       = '0;
    for (int unsigned k = 0; k < DRVRS; k++) begin
      idx = {1'b0, ptr_q} + 5'(k);
      if (idx >= 5'(DRVRS)) begin
        idx = idx - 5'(DRVRS);
      end
      if (!found && pndng_ext[idx[3:0]]) begin
        found = 1'b1;
        sel   = idx[3:0];
      end
    end
  end

  logic [PCKG_SZ-1:0] head;

  always_comb begin
    head = '0;
    for (int unsigned i = 0; i < DRVRS; i++) begin
      if (sel == 4'(i)) begin
        head = bus.D_pop[i*PCKG_SZ +: PCKG_SZ];
      end
    end
  end

  // Destination decode of the captured packet.
  logic [7:0]       dest;
  logic [DRVRS-1:0] route_mask;
  logic             route_ok;

  assign dest = pkt_q[PCKG_SZ-1 -: 8];

  always_comb begin
    route_mask = '0;
    route_ok   = 1'b0;
    if (dest == BROADCAST) begin
      route_ok = 1'b1;
      for (int unsigned i = 0; i < DRVRS; i++) begin
        route_mask[i] = (grant_q != 4'(i));
      end
    end else if (dest < 8'(DRVRS)) begin
      route_ok = 1'b1;
      for (int unsigned i = 0; i < DRVRS; i++) begin
        route_mask[i] = (dest == 8'(i));
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    pkt_d    = pkt_q;
    d_push_d = d_push_q;
    pop_d    = '0;
    push_d   = '0;
    busy_d   = busy_q;
    xfer_d   = xfer_q;
    drop_d   = drop_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          pkt_d   = head;
          grant_d = sel;
          ptr_d   = (sel == 4'(DRVRS - 1)) ? 4'd0 : sel + 4'd1;
          for (int unsigned i = 0; i < DRVRS; i++) begin
            pop_d[i] = (sel == 4'(i));
          end
          busy_d  = 1'b1;
          state_d = StPop;
        end
      end
      StPop: begin
        push_d = route_mask;
        if (route_ok) begin
          // D_push only changes on an actual delivery so it keeps the last delivered packet.
          d_push_d = pkt_q;
          xfer_d   = xfer_q + 16'd1;
        end else if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
        state_d = StPush;
      end
      StPush: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      grant_q  <= '0;
      pkt_q    <= '0;
      d_push_q <= '0;
      pop_q    <= '0;
      push_q   <= '0;
      busy_q   <= 1'b0;
      xfer_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      pkt_q    <= pkt_d;
      d_push_q <= d_push_d;
      pop_q    <= pop_d;
      push_q   <= push_d;
      busy_q   <= busy_d;
      xfer_q   <= xfer_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.pop      = pop_q;
  assign bus.push     = push_q;
  assign bus.D_push   = d_push_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
  assign bus.xfer_cnt = xfer_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_rr_sched.sv
// Directed bench for bus_rr_sched: expected deliveries go into a scoreboard queue when a
// request is posted and are popped by a monitor whenever the scheduler pushes.
module tb_bus_rr_sched;

  localparam int unsigned N = 8;
  localparam int unsigned W = 24;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_rr_sched_if #(.DRVRS(N), .PCKG_SZ(W)) ifc ();

  bus_rr_sched #(
    .DRVRS    (N),
    .PCKG_SZ  (W),
    .BROADCAST(8'hFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.master)
  );

  logic [W-1:0] slice [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ifc.D_pop[i*W +: W] = slice[i];
    end
  end

  typedef struct packed {
    logic [N-1:0] mask;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every push must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && ifc.push !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_push", 32'(ifc.push), 32'h0);
      end else begin
        e = sb.pop_front();
        check("push_mask", 32'(ifc.push), 32'(e.mask));
        check("d_push", 32'(ifc.D_push), 32'(e.data));
        check("pop_push_overlap", 32'(ifc.pop), 32'h0);
      end
    end
  end

  // One full transaction; pndng and slices must already be set. mask==0 means "drop expected".
  task automatic run_txn(input int drv, input logic [N-1:0] mask, input bit clear_after,
                         input string tag);
    logic [N-1:0] oh;
    oh      = '0;
    oh[drv] = 1'b1;
    if (mask != '0) sb.push_back('{mask: mask, data: slice[drv]});
    @(posedge clk); #1;
    check({tag, "_pop"}, 32'(ifc.pop), 32'(oh));
    check({tag, "_grant"}, 32'(ifc.grant_id), 32'(drv));
    check({tag, "_busy"}, 32'(ifc.busy), 32'h1);
    if (clear_after) ifc.pndng = '0;
    @(posedge clk); #1;
    check({tag, "_pop_clear"}, 32'(ifc.pop), 32'h0);
    if (mask == '0) check({tag, "_no_push"}, 32'(ifc.push), 32'h0);
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(ifc.busy), 32'h0);
    check({tag, "_push_clear"}, 32'(ifc.push), 32'h0);
    if (mask != '0) check({tag, "_delivered"}, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    ifc.pndng = '0;
    for (int i = 0; i < N; i++) slice[i] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_pop", 32'(ifc.pop), 32'h0);
    check("rst_push", 32'(ifc.push), 32'h0);
    check("rst_d_push", 32'(ifc.D_push), 32'h0);
    check("rst_busy", 32'(ifc.busy), 32'h0);
    check("rst_grant", 32'(ifc.grant_id), 32'h0);
    check("rst_xfer", 32'(ifc.xfer_cnt), 32'h0);
    check("rst_drop", 32'(ifc.drop_cnt), 32'h0);

    // Single request to receiver 3 from driver 2.
    slice[2]  = 24'h03_00AB;
    ifc.pndng = 8'h04;
    run_txn(2, 8'h08, 1'b1, "single");
    check("single_xfer", 32'(ifc.xfer_cnt), 32'd1);

    // Fairness from a fresh pointer: all pending, all to receiver 0.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < N; i++) slice[i] = {8'h00, 16'hA000 + 16'(i)};
    ifc.pndng = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      run_txn(k % N, 8'h01, 1'b0, "rr");
    end
    ifc.pndng = '0;
    check("rr_xfer", 32'(ifc.xfer_cnt), 32'd16);

    // Broadcast from driver 5 excludes the source.
    slice[5]  = 24'hFF_1234;
    ifc.pndng = 8'h20;
    run_txn(5, 8'hDF, 1'b1, "bcast");
    check("bcast_xfer", 32'(ifc.xfer_cnt), 32'd17);

    // Destination 0x0A does not exist with 8 receivers.
    slice[1]  = 24'h0A_5555;
    ifc.pndng = 8'h02;
    run_txn(1, 8'h00, 1'b1, "inval");
    check("inval_drop", 32'(ifc.drop_cnt), 32'd1);
    check("inval_xfer", 32'(ifc.xfer_cnt), 32'd17);

    // Reset during the POP cycle of a grant to driver 3.
    slice[3]  = 24'h04_0033;
    ifc.pndng = 8'h08;
    @(posedge clk); #1;
    check("mid_pop", 32'(ifc.pop), 32'h08);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pop", 32'(ifc.pop), 32'h0);
    check("mid_rst_push", 32'(ifc.push), 32'h0);
    check("mid_rst_busy", 32'(ifc.busy), 32'h0);
    check("mid_rst_grant", 32'(ifc.grant_id), 32'h0);
    check("mid_rst_xfer", 32'(ifc.xfer_cnt), 32'h0);
    check("mid_rst_drop", 32'(ifc.drop_cnt), 32'h0);
    @(negedge clk); reset = 1'b0;
    run_txn(3, 8'h10, 1'b1, "after_rst");
    check("after_rst_xfer", 32'(ifc.xfer_cnt), 32'd1);

    // Move the pointer to 6, then drivers 0 and 1 must be reached by wrapping.
    slice[5]  = 24'h02_0001;
    ifc.pndng = 8'h20;
    run_txn(5, 8'h04, 1'b1, "to_ptr6");
    slice[0]  = 24'h06_0AAA;
    slice[1]  = 24'h07_0BBB;
    ifc.pndng = 8'h03;
    run_txn(0, 8'h40, 1'b0, "skip0");
    run_txn(1, 8'h80, 1'b1, "skip1");
    check("skip_xfer", 32'(ifc.xfer_cnt), 32'd4);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
